pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the enable (stall) and synchronous-clear (flush) controls of the IF/ID and ID/EX pipeline latches, covering:
  - load-use hazards
  - taken-branch squash
  - instruction-memory wait states
  - a multi-cycle mul/div unit, tracked by an internal FSM/counter
- Sits beside the datapath. Pure control; no data passes through it.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipe_hazard_ctrl_if.sv | 50 +++++
 rtl/pipe_hazard_ctrl_muldiv_seq.sv | 55 +++++
 rtl/pipe_hazard_ctrl.sv | 86 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared widths, mul/div state encoding and the latch control bundle
package pipe_ctrl_pkg;

  localparam int REG_W        = 5;
  localparam int MULDIV_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // Stall/flush controls for the IF/ID and ID/EX latches, shared with the latch modules
  typedef struct packed {
    logic stall_IF;
    logic stall_DEC;
    logic flush_DEC;
    logic stall_EX;
    logic flush_EX;
  } ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard inputs from the datapath and latch controls back to it
// HAZARD_PERF_CNT_EN adds the stall_cycles/flush_cycles counters.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = pipe_ctrl_pkg::REG_W
);

  logic [REG_W-1:0] rs_DEC;
  logic [REG_W-1:0] rt_DEC;
  logic [REG_W-1:0] writereg_EX;
  logic             regwrite_EX;
  logic             memtoreg_EX;
  logic             branch_taken_DEC;
  logic             muldiv_start_EX;
  logic             imem_ready;

  logic             stall_IF;
  logic             stall_DEC;
  logic             flush_DEC;
  logic             stall_EX;
  logic             flush_EX;
  logic             muldiv_busy;
  logic             muldiv_done;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]      stall_cycles;
  logic [31:0]      flush_cycles;
`endif

  // Datapath side
  modport master (
    output rs_DEC, rt_DEC, writereg_EX, regwrite_EX, memtoreg_EX,
    output branch_taken_DEC, muldiv_start_EX, imem_ready,
    input  stall_IF, stall_DEC, flush_DEC, stall_EX, flush_EX,
    input  muldiv_busy, muldiv_done
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cycles, flush_cycles
`endif
  );

  // Hazard controller side
  modport slave (
    input  rs_DEC, rt_DEC, writereg_EX, regwrite_EX, memtoreg_EX,
    input  branch_taken_DEC, muldiv_start_EX, imem_ready,
    output stall_IF, stall_DEC, flush_DEC, stall_EX, flush_EX,
    output muldiv_busy, muldiv_done
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cycles, flush_cycles
`endif
  );

endinterface

// File: rtl/pipe_hazard_ctrl_muldiv_seq.sv
// rtl/pipe_hazard_ctrl_muldiv_seq.sv - mul/div occupancy FSM: holds EX for MULDIV_CYCLES, then a one-cycle done
module muldiv_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic md,
  output logic busy,
  output logic done
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_DONE = DONE;

  // The start cycle itself counts as the first EX cycle, hence the -2 preload
  localparam logic [MULDIV_CNT_W-1:0] CNT_LOAD = MULDIV_CNT_W'(MULDIV_CYCLES - 2);

  logic [1:0]              state;
  logic [MULDIV_CNT_W-1:0] cnt;

  // Start is only sampled in IDLE: the level stays high while EX is held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt - MULDIV_CNT_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = !reset && (state == ST_BUSY);
  assign done = !reset && (state == ST_DONE);
  assign md   = !reset && ((state == ST_BUSY) || ((state == ST_IDLE) && start));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the IF/ID and ID/EX latches of the 5-stage pipeline
// HAZARD_PERF_CNT_EN adds the stall_cycles/flush_cycles performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter int REG_W         = pipe_ctrl_pkg::REG_W
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  logic  md;
  logic  lu;
  ctrl_t ctrl;

  muldiv_seq #(
    .MULDIV_CYCLES(MULDIV_CYCLES)
  ) u_muldiv_seq (
    .clk  (clk),
    .reset(reset),
    .start(hz.muldiv_start_EX),
    .md   (md),
    .busy (hz.muldiv_busy),
    .done (hz.muldiv_done)
  );

  // $0 is hardwired to zero, so a load targeting it never creates a dependency
  assign lu = hz.memtoreg_EX && hz.regwrite_EX &&
              (hz.writereg_EX != REG_W'(0)) &&
              ((hz.writereg_EX == hz.rs_DEC) || (hz.writereg_EX == hz.rt_DEC));

  always_comb begin
    ctrl = '0;
    if (reset) begin
      ctrl = '0;
    end else if (md) begin
      ctrl.stall_IF  = 1'b1;
      ctrl.stall_DEC = 1'b1;
      ctrl.stall_EX  = 1'b1;
    end else if (lu) begin
      ctrl.stall_IF  = 1'b1;
      ctrl.stall_DEC = 1'b1;
      ctrl.flush_EX  = 1'b1;
    end else begin
      if (hz.branch_taken_DEC) begin
        ctrl.flush_DEC = 1'b1;
      end
      // A missing fetch also delays a branch target, so PC holds on top of the squash
      if (!hz.imem_ready) begin
        ctrl.stall_IF  = 1'b1;
        ctrl.flush_DEC = 1'b1;
      end
    end
  end

  assign hz.stall_IF  = ctrl.stall_IF;
  assign hz.stall_DEC = ctrl.stall_DEC;
  assign hz.flush_DEC = ctrl.flush_DEC;
  assign hz.stall_EX  = ctrl.stall_EX;
  assign hz.flush_EX  = ctrl.flush_EX;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (ctrl.stall_DEC) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (ctrl.flush_DEC || ctrl.flush_EX) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_cycles = flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed-vector bench for pipe_hazard_ctrl with MULDIV_CYCLES=4
// Counter checks are compiled in when HAZARD_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

  // Output vector order: {stall_IF, stall_DEC, flush_DEC, stall_EX, flush_EX, muldiv_busy, muldiv_done}
  localparam logic [31:0] O_NONE = 32'b0000000;
  localparam logic [31:0] O_LU   = 32'b1100100;
  localparam logic [31:0] O_BR   = 32'b0010000;
  localparam logic [31:0] O_IM   = 32'b1010000;
  localparam logic [31:0] O_MDS  = 32'b1101000;
  localparam logic [31:0] O_MDB  = 32'b1101010;
  localparam logic [31:0] O_DN   = 32'b0000001;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_W(5)) hz ();

  pipe_hazard_ctrl #(
    .MULDIV_CYCLES(4),
    .REG_W        (5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b, want %0b", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {25'd0, hz.stall_IF, hz.stall_DEC, hz.flush_DEC, hz.stall_EX, hz.flush_EX,
            hz.muldiv_busy, hz.muldiv_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] exp);
    #1;
    chk(tag, outs(), exp);
  endtask

  // ld drives both memtoreg_EX and regwrite_EX
  task automatic set_in(input logic ld, input logic [4:0] w, input logic [4:0] s, input logic [4:0] t,
                        input logic br, input logic st, input logic im);
    hz.memtoreg_EX      = ld;
    hz.regwrite_EX      = ld;
    hz.writereg_EX      = w;
    hz.rs_DEC           = s;
    hz.rt_DEC           = t;
    hz.branch_taken_DEC = br;
    hz.muldiv_start_EX  = st;
    hz.imem_ready       = im;
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0);
    #3;
    look("reset_gate_pre_edge", O_NONE);
    tick();
    look("reset_gate", O_NONE);
`ifdef HAZARD_PERF_CNT_EN
    chk("reset_stall_cycles", hz.stall_cycles, 32'd0);
    chk("reset_flush_cycles", hz.flush_cycles, 32'd0);
`endif
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    look("idle", O_NONE);

    // Load-use
    tick(); set_in(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b1); look("lu_rs", O_LU);
    tick(); set_in(1'b0, 5'd0, 5'd8, 5'd3, 1'b0, 1'b0, 1'b1); look("lu_bubble_gone", O_NONE);
    tick(); set_in(1'b1, 5'd9, 5'd4, 5'd9, 1'b0, 1'b0, 1'b1); look("lu_rt", O_LU);
    tick(); set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); look("lu_reg0", O_NONE);
    tick(); set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1); hz.memtoreg_EX = 1'b0;
    look("no_load", O_NONE);
    tick(); set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1); hz.regwrite_EX = 1'b0;
    look("no_regwrite", O_NONE);
    tick(); set_in(1'b1, 5'd8, 5'd7, 5'd6, 1'b0, 1'b0, 1'b1); look("lu_no_match", O_NONE);

    // Branch
    tick(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1); look("branch", O_BR);
    tick(); set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1); look("branch_under_lu", O_LU);

    // Instruction-memory wait states
    for (int i = 0; i < 3; i++) begin
      tick(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); look("imem_wait", O_IM);
    end
    tick(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); look("branch_imem_wait", O_IM);

    // Mul/div with start held through BUSY and DONE
    tick(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1); look("md_start", O_MDS);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 1) set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0);
      else        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      look("md_busy", O_MDB);
    end
    tick(); look("md_done", O_DN);
    tick(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); look("md_back_idle", O_NONE);

    // Asynchronous reset in the first BUSY cycle (counter = 2)
    tick(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1); look("md2_start", O_MDS);
    tick(); look("md2_busy", O_MDB);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_mid_busy", outs(), O_NONE);
    tick(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); look("held_in_reset", O_NONE);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); look("post_reset_idle", O_NONE);
    end
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_clear_stall", hz.stall_cycles, 32'd0);
    chk("perf_clear_flush", hz.flush_cycles, 32'd0);
`endif

    // One load-use, one branch, one 4-cycle mul/div
    tick(); set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1); look("perf_lu", O_LU);
    tick(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1); look("perf_branch", O_BR);
    tick(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1); look("perf_md_start", O_MDS);
    for (int i = 0; i < 3; i++) begin
      tick(); look("perf_md_busy", O_MDB);
    end
    tick(); look("perf_md_done", O_DN);
    tick(); set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); look("perf_idle", O_NONE);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_cycles", hz.stall_cycles, 32'd5);
    chk("perf_flush_cycles", hz.flush_cycles, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
